branch_predictor_bht: RTL and testbench

Fetch-side partner of the EX-stage branch decision logic.
- At fetch, predicts the branch direction and target from a direct-mapped table. Each entry holds a 2-bit saturating counter plus a tagged target.
- At EX, takes the resolved outcome (the Branch signal computed from the Z/S/V/C flags) and trains the table.
- On a misprediction, raises a registered redirect/flush pulse toward the PC mux and pipeline registers.

---
 rtl/branch_predictor_bht_if.sv | 40 ++++
 rtl/branch_predictor_bht.sv | 152 +++++++++++++++
 tb/tb_branch_predictor_bht.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_bht_if.sv
// Fetch/EX bundle between the pipeline and the branch history table.
// The pipeline drives fetch lookups and EX resolutions; the table returns predictions and redirects.
interface branch_predictor_bht_if #(
    parameter int N     = 32,
    parameter int IDX_W = 4
);
    logic         fetch_valid;
    logic [N-1:0] fetch_pc;
    logic         pred_taken;
    logic [N-1:0] pred_target;

    // EX signals are sampled on every rising edge; ex_valid & ex_is_branch qualifies
    // a resolution, there is no backpressure (the table always accepts it).
    logic         ex_valid;
    logic         ex_is_branch;
    logic [N-1:0] ex_pc;
    logic         ex_taken;
    logic [N-1:0] ex_target;
    logic         ex_pred_taken;
    logic [N-1:0] ex_pred_target;

    logic         mispredict;
    logic [N-1:0] redirect_pc;

    modport master (
        output fetch_valid, fetch_pc,
        input  pred_taken, pred_target,
        output ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
        output ex_pred_taken, ex_pred_target,
        input  mispredict, redirect_pc
    );

    modport slave (
        input  fetch_valid, fetch_pc,
        output pred_taken, pred_target,
        input  ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
        input  ex_pred_taken, ex_pred_target,
        output mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BHT: 2-bit counters plus tagged targets, trained at EX, with a registered flush pulse.
// Optional macro BHT_STATS_EN adds saturating branch/mispredict counters.
module branch_predictor_bht #(
    parameter int N     = 32,
    parameter int IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predictor_bht_if.slave bus
`ifdef BHT_STATS_EN
    ,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts
`endif
);
    localparam int DEPTH = 2 ** IDX_W;
    localparam int TAG_W = N - IDX_W - 2;
    localparam logic [N-1:0] PC_INC = N'(4);

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    logic             valid_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [N-1:0]     target_q [DEPTH];
    logic [1:0]       ctr_q    [DEPTH];

    logic             valid_d  [DEPTH];
    logic [TAG_W-1:0] tag_d    [DEPTH];
    logic [N-1:0]     target_d [DEPTH];
    logic [1:0]       ctr_d    [DEPTH];

    logic         mispredict_q, mispredict_d;
    logic [N-1:0] redirect_q, redirect_d;

    // ---------------- fetch lookup (reads registered state only) ----------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             f_taken;

    assign f_idx   = bus.fetch_pc[IDX_W+1:2];
    assign f_tag   = bus.fetch_pc[N-1:IDX_W+2];
    assign f_hit   = bus.fetch_valid & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
    assign f_taken = f_hit & ctr_q[f_idx][1];

    assign bus.pred_taken  = f_taken;
    assign bus.pred_target = f_taken ? target_q[f_idx] : bus.fetch_pc + PC_INC;

    // ---------------- EX resolution ----------------
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_upd;
    logic             e_hit;
    logic             e_wrong;

    assign e_idx   = bus.ex_pc[IDX_W+1:2];
    assign e_tag   = bus.ex_pc[N-1:IDX_W+2];
    assign e_upd   = bus.ex_valid & bus.ex_is_branch;
    assign e_hit   = valid_q[e_idx] & (tag_q[e_idx] == e_tag);
    assign e_wrong = (bus.ex_taken != bus.ex_pred_taken) |
                     (bus.ex_taken & bus.ex_pred_taken & (bus.ex_target != bus.ex_pred_target));

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (e_upd) begin
            if (e_hit) begin
                if (bus.ex_taken) begin
                    target_d[e_idx] = bus.ex_target;
                    if (ctr_q[e_idx] != CTR_ST) begin
                        ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
                    end
                end else if (ctr_q[e_idx] != CTR_SNT) begin
                    ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
                end
            end else if (bus.ex_taken) begin
                // Only taken branches may claim (or steal) an entry.
                valid_d[e_idx]  = 1'b1;
                tag_d[e_idx]    = e_tag;
                target_d[e_idx] = bus.ex_target;
                ctr_d[e_idx]    = CTR_WT;
            end
        end
    end

    always_comb begin
        mispredict_d = e_upd & e_wrong;
        redirect_d   = redirect_q;
        if (e_upd & e_wrong) begin
            redirect_d = bus.ex_taken ? bus.ex_target : bus.ex_pc + PC_INC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            target_q     <= target_d;
            ctr_q        <= ctr_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
        end
    end

    assign bus.mispredict  = mispredict_q;
    assign bus.redirect_pc = redirect_q;

`ifdef BHT_STATS_EN
    logic [31:0] branches_q, branches_d;
    logic [31:0] mispredicts_q, mispredicts_d;

    always_comb begin
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        if (e_upd && branches_q != 32'hFFFF_FFFF) begin
            branches_d = branches_q + 32'd1;
        end
        if (mispredict_d && mispredicts_q != 32'hFFFF_FFFF) begin
            mispredicts_d = mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`else
    // Counter-free build: the hardware statistics block is simply absent.
`endif
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed self-checking bench for branch_predictor_bht (lookup, training, redirect, alias, reset).
// Build with +define+BHT_STATS_EN to also check the statistics counters.
module tb_branch_predictor_bht;
    localparam int N     = 32;
    localparam int IDX_W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

`ifdef BHT_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
    logic [31:0] exp_branches;
    logic [31:0] exp_mispredicts;
`endif

    branch_predictor_bht_if #(.N(N), .IDX_W(IDX_W)) bus ();

    branch_predictor_bht #(.N(N), .IDX_W(IDX_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus)
`ifdef BHT_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.fetch_valid    = 1'b0;
        bus.fetch_pc       = '0;
        bus.ex_valid       = 1'b0;
        bus.ex_is_branch   = 1'b0;
        bus.ex_pc          = '0;
        bus.ex_taken       = 1'b0;
        bus.ex_target      = '0;
        bus.ex_pred_taken  = 1'b0;
        bus.ex_pred_target = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one EX resolution for exactly one rising edge, then drop ex_valid.
    task automatic ex_resolve(input logic is_br, input logic [N-1:0] pc, input logic taken,
                              input logic [N-1:0] target, input logic ptaken,
                              input logic [N-1:0] ptarget);
        bus.ex_valid       = 1'b1;
        bus.ex_is_branch   = is_br;
        bus.ex_pc          = pc;
        bus.ex_taken       = taken;
        bus.ex_target      = target;
        bus.ex_pred_taken  = ptaken;
        bus.ex_pred_target = ptarget;
`ifdef BHT_STATS_EN
        if (is_br) begin
            exp_branches = exp_branches + 32'd1;
            if ((taken != ptaken) || (taken && ptaken && target != ptarget))
                exp_mispredicts = exp_mispredicts + 32'd1;
        end
`endif
        step();
        bus.ex_valid = 1'b0;
    endtask

    task automatic check_lookup(input string name, input logic [N-1:0] pc,
                                input logic exp_taken, input logic [N-1:0] exp_target);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc;
        #1;
        n_checks++;
        if (bus.pred_taken !== exp_taken || bus.pred_target !== exp_target) begin
            n_errors++;
            $display("FAIL %s: pred_taken=%0b pred_target=%h, expected %0b %h",
                     name, bus.pred_taken, bus.pred_target, exp_taken, exp_target);
        end
    endtask

    task automatic check_mp(input string name, input logic exp_mp, input logic [N-1:0] exp_pc);
        n_checks++;
        if (bus.mispredict !== exp_mp || bus.redirect_pc !== exp_pc) begin
            n_errors++;
            $display("FAIL %s: mispredict=%0b redirect_pc=%h, expected %0b %h",
                     name, bus.mispredict, bus.redirect_pc, exp_mp, exp_pc);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check_lookup("reset_lookup", 32'h40, 1'b0, 32'h44);
        check_mp("reset_mp", 1'b0, 32'h0);
`ifdef BHT_STATS_EN
        exp_branches    = '0;
        exp_mispredicts = '0;
`endif
        rst = 1'b1;
        step();
        check_mp("reset_release_mp", 1'b0, 32'h0);
    endtask

    task automatic test_cold_taken();
        ex_resolve(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        check_mp("cold_mp", 1'b1, 32'h100);
        check_lookup("cold_lookup", 32'h40, 1'b1, 32'h100);
        step();
        check_mp("cold_pulse_one_cycle", 1'b0, 32'h100);
    endtask

    task automatic test_training();
        for (int i = 0; i < 3; i++) begin
            ex_resolve(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
            check_mp("train_taken_no_mp", 1'b0, 32'h100);
        end
        ex_resolve(1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        check_mp("train_nt1_mp", 1'b1, 32'h44);
        check_lookup("train_nt1_still_taken", 32'h40, 1'b1, 32'h100);
        ex_resolve(1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        check_mp("train_nt2_mp", 1'b1, 32'h44);
        check_lookup("train_nt2_not_taken", 32'h40, 1'b0, 32'h44);
        bus.fetch_valid = 1'b0;
        ex_resolve(1'b1, 32'h40, 1'b0, 32'h100, 1'b0, 32'h0);
        check_mp("train_nt3_correct", 1'b0, 32'h44);
        check_lookup("train_snt_not_taken", 32'h40, 1'b0, 32'h44);
    endtask

    task automatic test_target_change();
        // SNT -> WNT -> WT, then a taken hit to a new target.
        ex_resolve(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        ex_resolve(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        check_lookup("tgt_rewarm", 32'h40, 1'b1, 32'h100);
        ex_resolve(1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h100);
        check_mp("tgt_change_mp", 1'b1, 32'h200);
        check_lookup("tgt_change_lookup", 32'h40, 1'b1, 32'h200);
        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = 32'h40;
        #1;
        n_checks++;
        if (bus.pred_taken !== 1'b0) begin
            n_errors++;
            $display("FAIL fetch_valid_gate: pred_taken=%0b expected 0", bus.pred_taken);
        end
    endtask

    task automatic test_alias_hazard();
        bus.fetch_valid    = 1'b1;
        bus.fetch_pc       = 32'h40;
        bus.ex_valid       = 1'b1;
        bus.ex_is_branch   = 1'b1;
        bus.ex_pc          = 32'h80;
        bus.ex_taken       = 1'b1;
        bus.ex_target      = 32'h300;
        bus.ex_pred_taken  = 1'b0;
        bus.ex_pred_target = 32'h0;
`ifdef BHT_STATS_EN
        exp_branches    = exp_branches + 32'd1;
        exp_mispredicts = exp_mispredicts + 32'd1;
`endif
        @(posedge clk);
        n_checks++;
        if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h200) begin
            n_errors++;
            $display("FAIL alias_read_before_write: pred_taken=%0b pred_target=%h, expected 1 00000200",
                     bus.pred_taken, bus.pred_target);
        end
        #1;
        bus.ex_valid = 1'b0;
        check_mp("alias_alloc_mp", 1'b1, 32'h300);
        check_lookup("alias_old_tag_miss", 32'h40, 1'b0, 32'h44);
        check_lookup("alias_new_tag_hit", 32'h80, 1'b1, 32'h300);
        ex_resolve(1'b1, 32'h40, 1'b0, 32'h500, 1'b0, 32'h0);
        check_lookup("alias_nt_no_replace", 32'h80, 1'b1, 32'h300);
        ex_resolve(1'b0, 32'h80, 1'b0, 32'h0, 1'b1, 32'h300);
        check_mp("non_branch_no_mp", 1'b0, 32'h300);
        check_lookup("non_branch_no_train", 32'h80, 1'b1, 32'h300);
    endtask

    task automatic test_back_to_back();
        ex_resolve(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h1000);
        check_mp("b2b_first_wrap", 1'b1, 32'h0);
        ex_resolve(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h200);
        check_mp("b2b_second", 1'b1, 32'h44);
        step();
        check_mp("b2b_end_hold", 1'b0, 32'h44);
        check_lookup("b2b_wrap_no_alloc", 32'hFFFF_FFFC, 1'b0, 32'h0);
    endtask

    task automatic test_async_reset();
        ex_resolve(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h300);
        check_mp("areset_pre_mp", 1'b1, 32'h84);
`ifdef BHT_STATS_EN
        n_checks++;
        if (stat_branches !== exp_branches || stat_mispredicts !== exp_mispredicts) begin
            n_errors++;
            $display("FAIL stats_count: branches=%0d mispredicts=%0d, expected %0d %0d",
                     stat_branches, stat_mispredicts, exp_branches, exp_mispredicts);
        end
`endif
        #1;
        rst = 1'b0;
        #1;
        check_mp("areset_mp_drop", 1'b0, 32'h0);
        check_lookup("areset_table_clear", 32'h80, 1'b0, 32'h84);
        check_lookup("areset_table_clear_40", 32'h40, 1'b0, 32'h44);
`ifdef BHT_STATS_EN
        n_checks++;
        if (stat_branches !== 32'h0 || stat_mispredicts !== 32'h0) begin
            n_errors++;
            $display("FAIL stats_reset: branches=%0d mispredicts=%0d, expected 0 0",
                     stat_branches, stat_mispredicts);
        end
`endif
        step();
        rst = 1'b1;
        step();
        check_mp("areset_after_release", 1'b0, 32'h0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
`ifdef BHT_STATS_EN
        exp_branches    = '0;
        exp_mispredicts = '0;
`endif
        test_reset();
        test_cold_taken();
        test_training();
        test_target_change();
        test_alias_hazard();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
